ram_fifo_ctrl_2x8: RTL and testbench

Two-entry FIFO controller that acts as the initiator on the `ram_2x8` port: it owns the write/read pointers and sequences `R_W_`, `ADDR_` and write data into an external 2x8 RAM. It returns read data to a consumer over a push/pop request interface with a ready handshake. It sits between a byte producer/consumer and one `ram_2x8` instance, and turns that bare storage array into an ordered queue with full/empty/error status.

---
 rtl/ram_fifo_ctrl_2x8.sv | 179 +++++++++++++++++
 tb/tb_ram_fifo_ctrl_2x8.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl_2x8.sv
// Two-entry, 8-bit FIFO controller driving an external ram_2x8 array.
// Owns the write/read pointers and occupancy, and sequences R_W_/ADDR_/write data
// so the bare RAM behaves as an ordered queue with full/empty/error status.
module ram_fifo_ctrl_2x8 (
    input  logic       CLK_,
    input  logic       CLR,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       ready,
    output logic [7:0] pop_data,
    output logic       pop_valid,
    output logic [1:0] count,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       underflow,
    output logic       R_W_,
    output logic       ADDR_,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR    = 2'd1,
        ST_RD    = 2'd2,
        ST_RD_WR = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       wp_q, wp_d;
    logic       rp_q, rp_d;
    logic [1:0] count_q, count_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] pop_data_q, pop_data_d;
    logic       pop_valid_q, pop_valid_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;

    logic       empty_s;
    logic       full_s;

    assign empty_s = (count_q == 2'd0);
    assign full_s  = (count_q == 2'd2);

    // FSM state register.
    always_ff @(posedge CLK_ or negedge CLR) begin
        if (!CLR) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: requests only matter in IDLE; a combined request on a
    // non-empty FIFO reads first so a full FIFO can accept both.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (push && pop) begin
                    if (empty_s) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_WR;
                    end
                end else if (push) begin
                    if (full_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WR;
                    end
                end else if (pop) begin
                    if (empty_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR:    state_d = ST_IDLE;
            ST_RD:    state_d = ST_IDLE;
            ST_RD_WR: state_d = ST_WR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from registered state: RAM direction and word select.
    always_comb begin
        ready = (state_q == ST_IDLE);
        R_W_  = (state_q == ST_WR);
        if (state_q == ST_WR) begin
            ADDR_ = wp_q;
        end else begin
            ADDR_ = rp_q;
        end
    end

    // Datapath next values: pointer/occupancy updates at the end of RAM cycles,
    // write-data capture and sticky error flags on request decode.
    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        wdata_d     = wdata_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        case (state_q)
            ST_IDLE: begin
                if (push && (pop || !full_s)) begin
                    wdata_d = push_data;
                end else begin
                    wdata_d = wdata_q;
                end
                if (push && !pop && full_s) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
                if (pop && empty_s) begin
                    unf_d = 1'b1;
                end else begin
                    unf_d = unf_q;
                end
            end
            ST_WR: begin
                wp_d    = ~wp_q;
                count_d = count_q + 2'd1;
            end
            ST_RD, ST_RD_WR: begin
                pop_data_d  = ram_rdata;
                pop_valid_d = 1'b1;
                rp_d        = ~rp_q;
                count_d     = count_q - 2'd1;
            end
            default: begin
                wp_d = wp_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLK_ or negedge CLR) begin
        if (!CLR) begin
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            count_q     <= 2'd0;
            wdata_q     <= 8'h00;
            pop_data_q  <= 8'h00;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            wdata_q     <= wdata_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign ram_wdata = wdata_q;
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign count     = count_q;
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_ram_fifo_ctrl_2x8.sv
// Bench for ram_fifo_ctrl_2x8: directed scenarios plus random traffic, checked
// every cycle against a queue-based transaction model and an external RAM model.
module tb_ram_fifo_ctrl_2x8;

    logic       CLK_ = 1'b0;
    logic       CLR  = 1'b0;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       pop  = 1'b0;
    logic       ready;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic [1:0] count;
    logic       empty, full, overflow, underflow;
    logic       R_W_, ADDR_;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    ram_fifo_ctrl_2x8 dut (
        .CLK_(CLK_), .CLR(CLR), .push(push), .push_data(push_data), .pop(pop),
        .ready(ready), .pop_data(pop_data), .pop_valid(pop_valid), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow),
        .R_W_(R_W_), .ADDR_(ADDR_), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 CLK_ = ~CLK_;

    // External 2x8 RAM: write on the edge ending an R_W_=1 cycle, combinational read.
    logic [7:0] mem [2];
    initial begin
        mem[0] = 8'hEE;
        mem[1] = 8'hEE;
    end
    always @(posedge CLK_) begin
        if (R_W_) mem[ADDR_] <= ram_wdata;
    end
    assign ram_rdata = mem[ADDR_];

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference model.
    logic [7:0] q [$];
    bit         m_ovf, m_unf;
    int         busy;          // cycles until ready again
    bit         s0_pop, s0_push, s1_push;
    logic [7:0] pend_byte;
    int         wr_total, rd_total;
    bit         exp_valid;
    logic [7:0] last_data;

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_unf = 0; busy = 0;
        s0_pop = 0; s0_push = 0; s1_push = 0;
        wr_total = 0; rd_total = 0;
        exp_valid = 0; last_data = 8'h00;
    endtask

    task automatic model_edge(input bit p, input logic [7:0] d, input bit o);
        exp_valid = 0;
        if (busy > 0) begin
            if (s0_pop) begin
                last_data = q.pop_front();
                exp_valid = 1;
                rd_total++;
            end
            if (s0_push) begin
                q.push_back(pend_byte);
                wr_total++;
            end
            s0_pop = 0; s0_push = s1_push; s1_push = 0;
            busy--;
        end else if (p && o) begin
            pend_byte = d;
            if (q.size() == 0) begin
                m_unf = 1; s0_push = 1; busy = 1;
            end else begin
                s0_pop = 1; s1_push = 1; busy = 2;
            end
        end else if (p) begin
            if (q.size() == 2) m_ovf = 1;
            else begin pend_byte = d; s0_push = 1; busy = 1; end
        end else if (o) begin
            if (q.size() == 0) m_unf = 1;
            else begin s0_pop = 1; busy = 1; end
        end
    endtask

    task automatic check_outputs();
        check_eq("ready", ready, (busy == 0));
        check_eq("count", count, q.size());
        check_eq("empty", empty, (q.size() == 0));
        check_eq("full", full, (q.size() == 2));
        check_eq("overflow", overflow, m_ovf);
        check_eq("underflow", underflow, m_unf);
        check_eq("pop_valid", pop_valid, exp_valid);
        check_eq("pop_data", pop_data, last_data);
        check_eq("R_W_", R_W_, s0_push);
        if (s0_push) begin
            check_eq("wr_addr", ADDR_, wr_total % 2);
            check_eq("ram_wdata", ram_wdata, pend_byte);
        end
        if (s0_pop) check_eq("rd_addr", ADDR_, rd_total % 2);
    endtask

    // One clock cycle with the given request levels, then check at the falling edge.
    task automatic step(input bit p, input logic [7:0] d, input bit o);
        push = p; push_data = d; pop = o;
        @(posedge CLK_);
        model_edge(p, d, o);
        @(negedge CLK_);
        check_outputs();
    endtask

    // Issue a request and idle until the model says the controller is free.
    task automatic req(input bit p, input logic [7:0] d, input bit o);
        step(p, d, o);
        for (int i = 0; i < 4 && busy > 0; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs checked before any edge.
    task automatic do_reset();
        #2;
        CLR = 1'b0;
        push = 1'b0; pop = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_eq("rst_addr", ADDR_, 1'b0);
        check_eq("rst_wdata", ram_wdata, 8'h00);
        @(negedge CLK_);
        CLR = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge CLK_);
        do_reset();

        // Fill and read back, overflow at full.
        req(1'b1, 8'hA5, 1'b0);
        req(1'b1, 8'h3C, 1'b0);
        req(1'b1, 8'hFF, 1'b0);
        check_eq("ovf_set", overflow, 1'b1);
        req(1'b0, 8'h00, 1'b1);
        check_eq("first_pop", pop_data, 8'hA5);
        req(1'b0, 8'h00, 1'b1);
        check_eq("second_pop", pop_data, 8'h3C);

        // Underflow on empty, then push+pop on empty.
        req(1'b0, 8'h00, 1'b1);
        req(1'b1, 8'h11, 1'b1);
        check_eq("pushpop_empty_cnt", count, 2'd1);

        // Simultaneous at full with wrapped pointers (rp=1).
        do_reset();
        req(1'b1, 8'h00, 1'b0);
        req(1'b0, 8'h00, 1'b1);
        req(1'b1, 8'h01, 1'b0);
        req(1'b1, 8'h02, 1'b0);
        req(1'b1, 8'h03, 1'b1);
        check_eq("rdwr_data", pop_data, 8'h01);
        check_eq("rdwr_count", count, 2'd2);
        req(1'b0, 8'h00, 1'b1);
        check_eq("wrap_pop2", pop_data, 8'h02);
        req(1'b0, 8'h00, 1'b1);
        check_eq("wrap_pop3", pop_data, 8'h03);

        // Busy ignore: second request arrives during the WR cycle.
        do_reset();
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h66, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check_eq("busy_count", count, 2'd1);

        // Random traffic with requests held regardless of ready, occasional reset.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
